// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, counter width.
package md_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_if.sv
// E-stage request bus into the md unit and the HI/LO/busy results back to the pipeline.
interface md_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit {hi,lo} result generator for mult/multu/div/divu.
module md_arith
  import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result
);

    logic               w_b_zero;
    logic               w_ovf;
    logic signed [31:0] w_as;
    logic signed [31:0] w_bs_safe;
    logic [31:0]        w_bu_safe;
    logic signed [63:0] w_mul_s;
    logic [63:0]        w_mul_u;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;

    assign w_b_zero = (i_b == 32'h0);
    assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_as     = $signed(i_a);

    // Divisors are steered to 1 in the zero/overflow cases so the dividers never see them.
    assign w_bs_safe = (w_b_zero || w_ovf) ? 32'sd1 : $signed(i_b);
    assign w_bu_safe = w_b_zero ? 32'd1 : i_b;

    assign w_mul_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_mul_u = {32'h0, i_a} * {32'h0, i_b};
    assign w_sq    = w_as / w_bs_safe;
    assign w_sr    = w_as % w_bs_safe;
    assign w_uq    = i_a / w_bu_safe;
    assign w_ur    = i_a % w_bu_safe;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        o_result = 64'h0;
        case (i_op)
            OP_MULT:  o_result = w_mul_s;
            OP_MULTU: o_result = w_mul_u;
            OP_DIV: begin
                if (w_b_zero)   o_result = {i_a, 32'hFFFF_FFFF};
                else if (w_ovf) o_result = {32'h0, 32'h8000_0000};
                else            o_result = {w_sr, w_sq};
            end
            OP_DIVU: begin
                if (w_b_zero) o_result = {i_a, 32'hFFFF_FFFF};
                else          o_result = {w_ur, w_uq};
            end
            default: o_result = 64'h0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy covers the modelled latency.
module md_unit
  import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  io
);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_pend;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [63:0]      w_pend_nxt;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      w_lo_nxt;
    logic [63:0]      w_result;

    md_arith u_arith (
        .i_op     (io.op),
        .i_a      (io.a),
        .i_b      (io.b),
        .o_result (w_result)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (io.start) begin
                    case (io.op)
                        OP_MULT, OP_MULTU: begin
                            w_pend_nxt  = w_result;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_pend_nxt  = w_result;
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                            w_state_nxt = ST_RUN;
                        end
                        OP_MTHI: w_hi_nxt = io.a;
                        OP_MTLO: w_lo_nxt = io.a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Requests arriving here are dropped; only the countdown advances.
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    {w_hi_nxt, w_lo_nxt} = r_pend;
                    w_state_nxt          = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the pending result is reset along with HI/LO so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign io.busy = (r_state == ST_RUN);
    assign io.hi   = r_hi;
    assign io.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO and latency expectations.
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    md_if u_if ();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits on a negedge; request is sampled by the next posedge, return is the negedge after it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.start = 1'b1;
        u_if.op    = op;
        u_if.a     = a;
        u_if.b     = b;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.op    = OP_NONE;
    endtask

    // Counts negedge samples with busy high (bounded) and flags any HI/LO change meanwhile.
    task automatic wait_done(output int n, output logic changed);
        logic [31:0] hi0, lo0;
        hi0 = u_if.hi;
        lo0 = u_if.lo;
        n = 0;
        changed = 1'b0;
        while (u_if.busy && n < 40) begin
            if (u_if.hi !== hi0 || u_if.lo !== lo0) changed = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input int n, input int n_exp,
                                input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        checks++;
        if (n !== n_exp) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d expected %0d", name, n, n_exp);
        end
        checks++;
        if (u_if.hi !== hi_exp) begin
            errors++;
            $display("FAIL %s_hi got %08h expected %08h", name, u_if.hi, hi_exp);
        end
        checks++;
        if (u_if.lo !== lo_exp) begin
            errors++;
            $display("FAIL %s_lo got %08h expected %08h", name, u_if.lo, lo_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %0b expected 0", u_if.busy);
        end
        checks++;
        if (u_if.hi !== 32'h0) begin
            errors++;
            $display("FAIL reset_hi got %08h expected 00000000", u_if.hi);
        end
        checks++;
        if (u_if.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_lo got %08h expected 00000000", u_if.lo);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        logic changed;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(n, changed);
        checks++;
        if (changed !== 1'b0) begin
            errors++;
            $display("FAIL mult_hold got %0b expected 0", changed);
        end
        check_result("mult", n, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, changed);
        check_result("multu", n, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    endtask

    task automatic test_div();
        int n;
        logic changed;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, changed);
        checks++;
        if (changed !== 1'b0) begin
            errors++;
            $display("FAIL div_hold got %0b expected 0", changed);
        end
        check_result("div_neg", n, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'd100, 32'hFFFF_FFF9);
        wait_done(n, changed);
        check_result("div_negdivisor", n, 10, 32'h0000_0002, 32'hFFFF_FFF2);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd16);
        wait_done(n, changed);
        check_result("divu", n, 10, 32'h0000_000F, 32'h0FFF_FFFF);
    endtask

    task automatic test_div_corner();
        int n;
        logic changed;
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done(n, changed);
        check_result("divu_zero", n, 10, 32'h0000_0007, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'hFFFF_FFF0, 32'd0);
        wait_done(n, changed);
        check_result("div_zero", n, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, changed);
        check_result("div_ovf", n, 10, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo0;
        lo0 = u_if.lo;
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.hi !== 32'h1234_5678 || u_if.lo !== lo0) begin
            errors++;
            $display("FAIL mthi got busy=%0b hi=%08h lo=%08h expected busy=0 hi=12345678 lo=%08h",
                     u_if.busy, u_if.hi, u_if.lo, lo0);
        end
        issue(OP_MTLO, 32'h0000_ABCD, 32'h0);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.hi !== 32'h1234_5678 || u_if.lo !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL mtlo got busy=%0b hi=%08h lo=%08h expected busy=0 hi=12345678 lo=0000abcd",
                     u_if.busy, u_if.hi, u_if.lo);
        end
        issue(3'd7, 32'hDEAD_BEEF, 32'h1);
        issue(OP_NONE, 32'hCAFE_F00D, 32'h2);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.hi !== 32'h1234_5678 || u_if.lo !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL noop_ops got busy=%0b hi=%08h lo=%08h expected busy=0 hi=12345678 lo=0000abcd",
                     u_if.busy, u_if.hi, u_if.lo);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        issue(OP_DIV, 32'd100, 32'd7);
        n = 0;
        while (u_if.busy && n < 40) begin
            if (n == 2) begin
                u_if.start = 1'b1;
                u_if.op    = OP_MTLO;
                u_if.a     = 32'd5;
            end else if (n == 4) begin
                u_if.start = 1'b1;
                u_if.op    = OP_MULT;
                u_if.a     = 32'd9;
                u_if.b     = 32'd9;
            end else begin
                u_if.start = 1'b0;
                u_if.op    = OP_NONE;
            end
            n++;
            @(negedge clk);
        end
        u_if.start = 1'b0;
        u_if.op    = OP_NONE;
        check_result("start_in_run", n, 10, 32'h0000_0002, 32'h0000_000E);
    endtask

    task automatic test_back_to_back();
        int n;
        logic changed;
        issue(OP_MULT, 32'd6, 32'd7);
        wait_done(n, changed);
        check_result("b2b_mult", n, 5, 32'h0, 32'd42);
        issue(OP_DIVU, 32'd42, 32'd5);
        wait_done(n, changed);
        check_result("b2b_divu", n, 10, 32'd2, 32'd8);
    endtask

    task automatic test_reset_mid_run();
        issue(OP_MULT, 32'd3, 32'd4);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (u_if.busy !== 1'b0 || u_if.hi !== 32'h0 || u_if.lo !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got busy=%0b hi=%08h lo=%08h expected all 0",
                     u_if.busy, u_if.hi, u_if.lo);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.hi !== 32'h0 || u_if.lo !== 32'h0) begin
            errors++;
            $display("FAIL post_reset got busy=%0b hi=%08h lo=%08h expected all 0",
                     u_if.busy, u_if.hi, u_if.lo);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        u_if.start = 1'b0;
        u_if.op    = OP_NONE;
        u_if.a     = 32'h0;
        u_if.b     = 32'h0;
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_mthi_mtlo();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in the execute stage, consumes E-stage operands for mult/multu/div/divu/mthi/mtlo, and produces the HI/LO registers read by mfhi/mflo. It models multi-cycle latency with a countdown FSM and exposes `busy` so the hazard logic can stall the decode stage.

## Interface
- `MULT_CYCLES`, default 5: cycles from accepted mult/multu to HI/LO update (1..15).
- `DIV_CYCLES`, default 10: cycles from accepted div/divu to HI/LO update (1..15).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; qualifies `op`, `a`, `b` this cycle.
- `op`  in  3  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a`  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- `b`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  operation in flight; HI/LO not yet valid.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- States: IDLE, RUN. Reset (reset=0) forces IDLE, `busy`=0, `hi`=0, `lo`=0, counter=0, pending result=0; effective immediately, no clock needed.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU: compute 64-bit result from `a`,`b`, store in pending register, load counter with MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, `start`=1, op MTHI/MTLO: write `a` to `hi`/`lo` at that edge; stay IDLE; `busy` never asserts.
- IDLE, `start`=1, op NONE or unlisted code: no effect.
- RUN: counter decrements each edge; on the edge where it reaches 0, `{hi,lo}` <= pending, go IDLE.
- `start` while RUN (any op, including MTHI/MTLO): ignored; hazard logic must never issue it, but the unit must not corrupt state.
- `hi`/`lo` hold previous values throughout RUN.
- MULT: signed 32x32 -> 64, `hi`=upper, `lo`=lower. MULTU: unsigned.
- DIV: signed; `lo`=quotient truncated toward zero, `hi`=remainder with sign of dividend. DIVU: unsigned.
- Divide by zero (DIV/DIVU, `b`=0): full latency; result `hi`=`a`, `lo`=32'hFFFF_FFFF.
- DIV overflow (`a`=32'h8000_0000, `b`=32'hFFFF_FFFF): `lo`=32'h8000_0000, `hi`=0.
- Reset mid-RUN: pending result discarded, `hi`/`lo` cleared to 0.

## Timing
- `start` sampled at edge E0; `busy`=1 from just after E0 until just after edge E(N), N = MULT_CYCLES or DIV_CYCLES.
- `hi`/`lo` update and `busy` fall together at E(N); mfhi/mflo may read in the cycle after E(N).
- Back-to-back: a new `start` is accepted in the first cycle with `busy`=0.
- MTHI/MTLO: zero latency beyond one edge; `busy` stays 0.
- Hazard rule for the consumer: stall D when (`busy` | `start`) and the D instruction is an md-class op.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package `md_pkg`: `op` encoding constants (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6), state encoding, counter width constant (4).
- The E-stage control decoder imports `md_pkg` for `op` generation.
- One sub-module is natural: `md_arith`, combinational 64-bit result generator (mult/div incl. zero and overflow rules), leaving the FSM/counter/registers in `md_unit`.

## Test plan
- Reset then MULT a=32'hFFFF_FFFE (-2), b=3 -> `busy` high exactly 5 cycles, then `hi`=32'hFFFF_FFFF, `lo`=32'hFFFF_FFFA.
- MULTU a=b=32'hFFFF_FFFF -> after 5 cycles `hi`=32'hFFFF_FFFE, `lo`=1.
- DIV a=-7, b=2 -> `busy` 10 cycles, `lo`=-3, `hi`=-1; DIVU a=7, b=0 -> `hi`=7, `lo`=32'hFFFF_FFFF.
- MTHI 32'h1234_5678 then MTLO 32'hABCD at consecutive edges -> `busy` stays 0, `hi`/`lo` update one edge each.
- DIV in flight, `start` with MTLO 5 at cycle 3 -> ignored; final `lo` is the quotient, not 5.
- MULT in flight, drop reset at cycle 2 asynchronously -> `busy`, `hi`, `lo` go 0 before next edge; no update after reset release.
